tt_um_jimktrains_vslc_scan_seq: RTL and testbench
=================================================

// Module: tt_um_jimktrains_vslc_scan_seq
// PURPOSE
//  Parametrised scan-cycle sequencer for the VSLC core; replaces the inline header/restart logic.
//  Parses the program header from the EEPROM reader byte stream, qualifies instruction bytes and
//  issues restart pulses. Latches the input image per scan in AUTO, external-TRIG or TIMED mode.
//  Sits between the eeprom_reader (byte source) and the executor (instruction sink).
// PARAMETERS
//  ADDR_W      10      program address width (1..16); header fields masked to ADDR_W bits
//  IN_W        8       input image width
//  CNT_W       8       scan counter width
//  WDT_CYCLES  65535   watchdog limit in clk cycles (used only with VSLC_SCAN_WATCHDOG_EN)
// PORTS
//  clk          in   1       single clock, all logic posedge
//  rst_n        in   1       asynchronous active-low reset
//  mode         in   2       0=AUTO 1=TRIG 2=TIMED 3=HOLD (never restart); sampled in DONE only
//  ext_trig     in   1       async external scan trigger, rising-edge sensitive
//  tick         in   1       1-cycle timer strobe for TIMED mode
//  rd_valid     in   1       reader byte strobe (1 cycle per byte)
//  rd_addr      in   16      address of byte on rd_data
//  rd_data      in   8       byte from reader
//  ui_in        in   IN_W    raw inputs
//  restart      out  1       1-cycle pulse: reader reloads from start_addr
//  start_addr   out  16      zero-extended program start address
//  instr_valid  out  1       rd_data is a program byte for the executor
//  scan_active  out  1       high in SYNC and RUN
//  in_cur       out  IN_W    input image for current scan
//  in_prev      out  IN_W    input image for previous scan
//  scan_count   out  CNT_W   completed scans, wraps
//  wdt_fault    out  1       sticky watchdog fault
// BEHAVIOUR
//  Reset: state=HEADER; all outputs 0; start/end regs 0; trig_pend=0; first_scan=1.
//  HEADER: on rd_valid, rd_addr 0/1/2/3 load start[15:8]/start[7:0]/end[15:8]/end[7:0];
//   other addresses ignored. After the addr-3 byte: end==0 -> HALT, else -> RESTART.
//   start<4 is clamped to 4. The header is parsed once per reset.
//  RESTART: restart=1 for exactly this cycle -> SYNC.
//  SYNC: discard every byte until rd_valid with rd_addr==start; assert instr_valid for that byte.
//   On that byte, latch inputs: in_cur<=ui_in, in_prev<=(first_scan?ui_in:in_cur), first_scan<=0.
//   Next state is RUN, or DONE if that byte's address >= end.
//  RUN: instr_valid = rd_valid (same cycle, combinational; zero latency).
//   rd_valid with rd_addr>=end -> DONE; the end byte itself is valid.
//  DONE: scan_count+1 on entry. AUTO -> RESTART next cycle; TRIG -> RESTART when trig_pend or
//   trig edge; TIMED -> RESTART on tick; HOLD -> stay. trig_pend/edge consumed on exit.
//  HALT: terminal until reset; instr_valid=0, restart=0.
//  ext_trig: 2-flop sync + edge detect, 3-clk latency. An edge outside DONE sets trig_pend
//   (1 deep; extra edges merge). trig_pend is cleared in non-TRIG modes.
//  Address compares use ADDR_W-bit masked rd_addr; equal start/end = 1-byte program.
//  Simultaneous tick and trig edge: only the current-mode source matters.
//  A mode change mid-scan takes effect at the next DONE.
// CONFIGURATION
//  VSLC_SCAN_WATCHDOG_EN defined: a counter runs while scan_active and clears on DONE entry.
//   Reaching WDT_CYCLES sets wdt_fault (sticky until reset) and forces HALT.
//  Undefined: no counter; wdt_fault tied 0; a stalled reader leaves the FSM in SYNC/RUN forever.
// TESTING
//  Header 00 10 00 13, AUTO -> restart 1 cycle after addr 3; bytes 0x10..0x13 instr_valid; count 1.
//  Header end=0000 -> HALT; no restart or instr_valid over 1000 cycles of stream.
//  TRIG mode, 2 ext_trig edges during RUN -> one restart per DONE, pend merged; count advances by 1.
//  Stale byte at addr 0x14 after restart, start=0x10 -> ignored in SYNC; scan completes normally.
//  ui_in 0x0F at scan1, 0xF0 at scan2 -> in_cur/in_prev 0F/0F then F0/0F.
//  WATCHDOG_EN, WDT_CYCLES=100, reader stalled in RUN -> wdt_fault at cycle 100, HALT; reset clears.

Source files
------------

// File: rtl/tt_um_jimktrains_vslc_scan_seq.sv
// rtl/tt_um_jimktrains_vslc_scan_seq.sv - VSLC scan-cycle sequencer: header parse, scan restart, input latching
// Optional scan watchdog enabled by defining VSLC_SCAN_WATCHDOG_EN.
module tt_um_jimktrains_vslc_scan_seq #(
  parameter int ADDR_W     = 10,
  parameter int IN_W       = 8,
  parameter int CNT_W      = 8,
  parameter int WDT_CYCLES = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             ext_trig,
  input  logic             tick,
  input  logic             rd_valid,
  input  logic [15:0]      rd_addr,
  input  logic [7:0]       rd_data,
  input  logic [IN_W-1:0]  ui_in,
  output logic             restart,
  output logic [15:0]      start_addr,
  output logic             instr_valid,
  output logic             scan_active,
  output logic [IN_W-1:0]  in_cur,
  output logic [IN_W-1:0]  in_prev,
  output logic [CNT_W-1:0] scan_count,
  output logic             wdt_fault
);

  typedef enum logic [2:0] {
    S_HEADER, S_RESTART, S_SYNC, S_RUN, S_DONE, S_HALT
  } state_t;

  localparam logic [1:0]  M_AUTO    = 2'd0;
  localparam logic [1:0]  M_TRIG    = 2'd1;
  localparam logic [1:0]  M_TIMED   = 2'd2;
  localparam logic [15:0] ADDR_MASK = 16'((32'd1 << ADDR_W) - 32'd1);

  state_t      state, state_raw, state_nxt;
  logic [15:0] start_r, end_r;
  logic [15:0] addr_m, start_m, start_clamp, end_new;
  logic        hdr_last, sync_hit, at_end;
  logic        first_scan, trig_pend, trig_edge, wdt_trip;
  logic [2:0]  trig_sync;

  assign addr_m      = rd_addr & ADDR_MASK;
  assign start_m     = start_r & ADDR_MASK;
  assign start_clamp = (start_m < 16'd4) ? 16'd4 : start_m;
  assign end_new     = {end_r[15:8], rd_data} & ADDR_MASK;
  assign hdr_last    = (state == S_HEADER) && rd_valid && (rd_addr == 16'd3);
  assign sync_hit    = (state == S_SYNC) && rd_valid && (addr_m == start_r);
  assign at_end      = (addr_m >= end_r);
  assign trig_edge   = trig_sync[1] & ~trig_sync[2];
  assign scan_active = (state == S_SYNC) || (state == S_RUN);
  assign start_addr  = start_r;

  always_comb begin
    state_raw   = state;
    restart     = 1'b0;
    instr_valid = 1'b0;
    case (state)
      S_HEADER:  if (hdr_last) state_raw = (end_new == 16'd0) ? S_HALT : S_RESTART;
      S_RESTART: begin
        restart   = 1'b1;
        state_raw = S_SYNC;
      end
      S_SYNC: if (sync_hit) begin
        instr_valid = 1'b1;
        state_raw   = at_end ? S_DONE : S_RUN;
      end
      S_RUN: begin
        instr_valid = rd_valid;
        if (rd_valid && at_end) state_raw = S_DONE;
      end
      S_DONE: begin
        case (mode)
          M_AUTO:  state_raw = S_RESTART;
          M_TRIG:  if (trig_pend || trig_edge) state_raw = S_RESTART;
          M_TIMED: if (tick) state_raw = S_RESTART;
          default: state_raw = S_DONE;
        endcase
      end
      S_HALT:  state_raw = S_HALT;
      default: state_raw = S_HALT;
    endcase
  end

  assign state_nxt = wdt_trip ? S_HALT : state_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_HEADER;
      trig_sync <= 3'b000;
    end else begin
      state     <= state_nxt;
      trig_sync <= {trig_sync[1:0], ext_trig};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_r    <= 16'd0;
      end_r      <= 16'd0;
      in_cur     <= '0;
      in_prev    <= '0;
      scan_count <= '0;
      first_scan <= 1'b1;
      trig_pend  <= 1'b0;
    end else begin
      if (state == S_HEADER && rd_valid) begin
        case (rd_addr)
          16'd0: start_r[15:8] <= rd_data;
          16'd1: start_r[7:0]  <= rd_data;
          16'd2: end_r[15:8]   <= rd_data;
          16'd3: begin
            start_r <= start_clamp;
            end_r   <= end_new;
          end
          default: ;
        endcase
      end
      if (sync_hit) begin
        in_cur     <= ui_in;
        in_prev    <= first_scan ? ui_in : in_cur;
        first_scan <= 1'b0;
      end
      if (state_nxt == S_DONE && state != S_DONE) scan_count <= scan_count + CNT_W'(1);
      // Pending trigger only survives in TRIG mode; it is consumed when DONE is left.
      if (mode != M_TRIG) trig_pend <= 1'b0;
      else if (state == S_DONE) begin
        if (state_nxt != S_DONE) trig_pend <= 1'b0;
      end else if (trig_edge) trig_pend <= 1'b1;
    end
  end

`ifdef VSLC_SCAN_WATCHDOG_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] wdt_cnt;

  // A scan finishing on the limit cycle wins over the watchdog.
  assign wdt_trip = scan_active && (wdt_cnt == WDT_LAST) && (state_raw != S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdt_cnt   <= '0;
      wdt_fault <= 1'b0;
    end else begin
      if (wdt_trip) wdt_fault <= 1'b1;
      if (scan_active && state_raw != S_DONE && !wdt_trip) wdt_cnt <= wdt_cnt + WDT_W'(1);
      else wdt_cnt <= '0;
    end
  end
`else
  logic wdt_cfg_unused;
  assign wdt_cfg_unused = (WDT_CYCLES != 0);
  assign wdt_trip       = 1'b0;
  assign wdt_fault      = 1'b0;
`endif

endmodule

// File: tb/tb_tt_um_jimktrains_vslc_scan_seq.sv
// tb/tb_tt_um_jimktrains_vslc_scan_seq.sv - randomized scoreboard bench for the VSLC scan sequencer
module tb_tt_um_jimktrains_vslc_scan_seq;
  localparam int WDT = 100;
  localparam logic [15:0] MASK = 16'h03FF;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        ext_trig = 1'b0, tick = 1'b0, rd_valid = 1'b0;
  logic [15:0] rd_addr = 16'd0;
  logic [7:0]  rd_data = 8'd0, ui_in = 8'd0;
  logic        restart, instr_valid, scan_active, wdt_fault;
  logic [15:0] start_addr;
  logic [7:0]  in_cur, in_prev, scan_count;

  tt_um_jimktrains_vslc_scan_seq #(.ADDR_W(10), .IN_W(8), .CNT_W(8), .WDT_CYCLES(WDT)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .ext_trig(ext_trig), .tick(tick),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data), .ui_in(ui_in),
    .restart(restart), .start_addr(start_addr), .instr_valid(instr_valid),
    .scan_active(scan_active), .in_cur(in_cur), .in_prev(in_prev),
    .scan_count(scan_count), .wdt_fault(wdt_fault)
  );

  always #5 clk = ~clk;

  int vectors = 0, errors = 0;
  logic [7:0] mem [1024];

  // reader emulation
  int   ptr, inject, inject_on_rs, gap_pct;
  logic stall, trig_v, ui_rand;
  logic [1:0] mode_v;
  logic [7:0] ui_val;

  // reference model
  logic [15:0] exp_q[$];
  int   cyc_no, rs_at, done_from, restarts, scans_m;
  logic waiting, in_scan_m, hdr_done, first_m, first_of_scan, sb_en;
  logic [15:0] exp_start, exp_end;
  logic [7:0]  exp_cur, exp_prev, exp_count;
  logic s_restart, s_active, s_fault;

  task automatic load_prog(input logic [15:0] s, input logic [15:0] e);
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[0] = s[15:8]; mem[1] = s[7:0]; mem[2] = e[15:8]; mem[3] = e[7:0];
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; rd_valid = 1'b0; ext_trig = 1'b0; tick = 1'b0;
    ptr = 0; inject = -1; inject_on_rs = -1; stall = 1'b0; trig_v = 1'b0;
    exp_q.delete(); cyc_no = 0; rs_at = -1; done_from = 0; restarts = 0; scans_m = 0;
    waiting = 1'b0; in_scan_m = 1'b0; hdr_done = 1'b0; first_m = 1'b1; first_of_scan = 1'b0;
    exp_start = 16'd0; exp_end = 16'd0; exp_cur = 8'd0; exp_prev = 8'd0; exp_count = 8'd0;
    sb_en = 1'b1;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock of reader stimulus plus scoreboard; returns at the next negedge.
  task automatic cycle();
    logic v, exp_iv, exp_rs;
    logic [15:0] a, sm;
    v = !stall && (gap_pct == 0 || int'($urandom_range(0, 99)) >= gap_pct);
    a = (inject >= 0) ? 16'(inject) : 16'(ptr);
    if (ui_rand) ui_val = 8'($urandom);
    rd_valid = v; rd_addr = a; rd_data = mem[a[9:0]];
    ui_in = ui_val; mode = mode_v; ext_trig = trig_v;
    tick = (mode_v == 2'd2) && ($urandom_range(0, 5) == 0);
    #1;
    s_restart = restart; s_active = scan_active; s_fault = wdt_fault;
    exp_iv = v && in_scan_m && exp_q.size() > 0 && ((a & MASK) == exp_q[0]);
    if (sb_en) begin
      vectors++;
      if (instr_valid !== exp_iv) begin
        errors++; $display("FAIL instr_valid cyc=%0d addr=%h got %b want %b", cyc_no, a, instr_valid, exp_iv);
      end
      vectors++;
      if (scan_active !== in_scan_m) begin
        errors++; $display("FAIL scan_active cyc=%0d got %b want %b", cyc_no, scan_active, in_scan_m);
      end
      vectors++;
      if (scan_count !== exp_count) begin
        errors++; $display("FAIL scan_count cyc=%0d got %0d want %0d", cyc_no, scan_count, exp_count);
      end
      vectors++;
      if (in_cur !== exp_cur || in_prev !== exp_prev) begin
        errors++; $display("FAIL in_image cyc=%0d got %h/%h want %h/%h", cyc_no, in_cur, in_prev, exp_cur, exp_prev);
      end
      if (mode_v != 2'd1) begin
        exp_rs = (cyc_no == rs_at);
        vectors++;
        if (restart !== exp_rs) begin
          errors++; $display("FAIL restart cyc=%0d got %b want %b", cyc_no, restart, exp_rs);
        end
      end
      vectors++;
      if (wdt_fault !== 1'b0) begin
        errors++; $display("FAIL wdt_fault_idle cyc=%0d got %b want 0", cyc_no, wdt_fault);
      end
    end
    if (!hdr_done && v && a == 16'd3) begin
      sm = {mem[0], mem[1]} & MASK;
      exp_start = (sm < 16'd4) ? 16'd4 : sm;
      exp_end = {mem[2], mem[3]} & MASK;
      hdr_done = 1'b1;
      if (exp_end != 16'd0) rs_at = cyc_no + 1;
    end
    if (waiting && mode_v == 2'd2 && cyc_no >= done_from && tick) begin
      rs_at = cyc_no + 1; waiting = 1'b0;
    end
    if (exp_iv) begin
      if (first_of_scan) begin
        exp_prev = first_m ? ui_val : exp_cur;
        exp_cur = ui_val; first_m = 1'b0; first_of_scan = 1'b0;
      end
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) begin
        exp_count++; scans_m++; in_scan_m = 1'b0; waiting = 1'b1; done_from = cyc_no + 1;
        if (mode_v == 2'd0) rs_at = cyc_no + 2;
      end
    end
    if (v) begin
      if (inject >= 0) inject = -1;
      else ptr++;
    end
    if (s_restart) begin
      restarts++;
      if (sb_en) begin
        vectors++;
        if (exp_q.size() != 0 || start_addr !== exp_start) begin
          errors++; $display("FAIL restart_ctx cyc=%0d pending=%0d start_addr=%h want %h", cyc_no, exp_q.size(), start_addr, exp_start);
        end
      end
      exp_q.delete();
      exp_q.push_back(exp_start);
      for (int x = int'(exp_start) + 1; x <= int'(exp_end); x++) exp_q.push_back(16'(x));
      in_scan_m = 1'b1; first_of_scan = 1'b1; waiting = 1'b0;
      ptr = int'(exp_start); inject = inject_on_rs; inject_on_rs = -1;
    end
    cyc_no++;
    @(negedge clk);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_scans(input int n, input int budget, input string name);
    int target, k;
    target = scans_m + n; k = 0;
    while (scans_m < target && k < budget) begin cycle(); k++; end
    vectors++;
    if (scans_m < target) begin
      errors++; $display("FAIL %s: %0d scans done, want %0d within %0d cycles", name, scans_m, target, budget);
    end
  endtask

  task automatic run_until_restarts(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (restarts < n && k < budget) begin cycle(); k++; end
    vectors++;
    if (restarts < n) begin
      errors++; $display("FAIL %s: %0d restarts, want %0d within %0d cycles", name, restarts, n, budget);
    end
  endtask

  task automatic test_reset();
    mode_v = 2'd0; gap_pct = 0; ui_rand = 1'b1;
    load_prog(16'h0010, 16'h0013);
    apply_reset();
    run_scans(2, 200, "reset_prerun");
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({restart, start_addr, instr_valid, scan_active, in_cur, in_prev, scan_count, wdt_fault} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rs=%b sa=%h iv=%b act=%b cur=%h prev=%h cnt=%0d wdt=%b want all 0",
               restart, start_addr, instr_valid, scan_active, in_cur, in_prev, scan_count, wdt_fault);
    end
    apply_reset();
  endtask

  task automatic test_header_auto();
    mode_v = 2'd0; gap_pct = 0; ui_rand = 1'b1;
    load_prog(16'h0010, 16'h0013);
    apply_reset();
    run_scans(1, 100, "header_auto");
    cycle();
    vectors++;
    if (scan_count !== 8'd1) begin
      errors++; $display("FAIL header_auto_count got %0d want 1", scan_count);
    end
    // start below 4 is clamped; equal start/end is a one-byte program
    load_prog(16'h0002, 16'h0006);
    apply_reset();
    run_scans(2, 100, "clamp_start");
    load_prog(16'h0020, 16'h0020);
    apply_reset();
    run_scans(3, 100, "one_byte_prog");
  endtask

  task automatic test_halt();
    mode_v = 2'd0; gap_pct = 0; ui_rand = 1'b1;
    load_prog(16'h0010, 16'h0000);
    apply_reset();
    run_cycles(1000);
    vectors++;
    if (restarts != 0 || scan_count !== 8'd0) begin
      errors++; $display("FAIL halt: restarts=%0d count=%0d want 0/0", restarts, scan_count);
    end
  endtask

  task automatic test_stale_byte();
    mode_v = 2'd0; gap_pct = 0; ui_rand = 1'b1;
    load_prog(16'h0010, 16'h0013);
    apply_reset();
    inject_on_rs = 16'h0014;
    run_scans(1, 100, "stale_first");
    inject_on_rs = 16'h0014;
    run_scans(1, 100, "stale_second");
  endtask

  task automatic test_input_image();
    mode_v = 2'd0; gap_pct = 0; ui_rand = 1'b0; ui_val = 8'h0F;
    load_prog(16'h0010, 16'h0013);
    apply_reset();
    run_scans(1, 100, "image_scan1");
    vectors++;
    if (in_cur !== 8'h0F || in_prev !== 8'h0F) begin
      errors++; $display("FAIL image_scan1 got %h/%h want 0f/0f", in_cur, in_prev);
    end
    ui_val = 8'hF0;
    run_scans(1, 100, "image_scan2");
    vectors++;
    if (in_cur !== 8'hF0 || in_prev !== 8'h0F) begin
      errors++; $display("FAIL image_scan2 got %h/%h want f0/0f", in_cur, in_prev);
    end
    ui_rand = 1'b1;
  endtask

  task automatic test_trig();
    mode_v = 2'd1; gap_pct = 0; ui_rand = 1'b1;
    load_prog(16'h0010, 16'h0030);
    apply_reset();
    run_until_restarts(1, 50, "trig_header");
    for (int i = 0; i < 20; i++) begin
      trig_v = (i >= 2 && i < 5) || (i >= 9 && i < 12);
      cycle();
    end
    trig_v = 1'b0;
    run_scans(1, 100, "trig_scan1");
    run_cycles(10);
    vectors++;
    if (restarts != 2) begin
      errors++; $display("FAIL trig_merge restarts=%0d want 2", restarts);
    end
    run_scans(1, 100, "trig_scan2");
    run_cycles(40);
    vectors++;
    if (restarts != 2 || scan_count !== 8'd2) begin
      errors++; $display("FAIL trig_wait restarts=%0d count=%0d want 2/2", restarts, scan_count);
    end
    trig_v = 1'b1; run_cycles(3); trig_v = 1'b0;
    run_cycles(10);
    vectors++;
    if (restarts != 3) begin
      errors++; $display("FAIL trig_in_done restarts=%0d want 3", restarts);
    end
    run_scans(1, 100, "trig_scan3");
  endtask

  task automatic test_random();
    logic [15:0] s, e;
    int sm, len;
    for (int it = 0; it < 12; it++) begin
      sm = int'($urandom_range(4, 16'h03E0));
      len = int'($urandom_range(0, 20));
      s = {6'($urandom), 10'(sm)};
      e = {6'($urandom), 10'(sm + len)};
      mode_v = (it % 3 == 2) ? 2'd2 : 2'd0;
      gap_pct = int'($urandom_range(0, 40));
      ui_rand = 1'b1;
      load_prog(s, e);
      apply_reset();
      run_scans(3, 1500, "random_scans");
    end
    mode_v = 2'd3; gap_pct = 10;
    load_prog(16'h0040, 16'h0048);
    apply_reset();
    run_scans(1, 200, "hold_scan");
    run_cycles(60);
    vectors++;
    if (restarts != 1 || scan_count !== 8'd1) begin
      errors++; $display("FAIL hold restarts=%0d count=%0d want 1/1", restarts, scan_count);
    end
  endtask

  task automatic test_watchdog();
    mode_v = 2'd0; gap_pct = 0; ui_rand = 1'b1;
    load_prog(16'h0010, 16'h0030);
    apply_reset();
    run_until_restarts(1, 50, "wdt_header");
    sb_en = 1'b0; stall = 1'b1;
`ifdef VSLC_SCAN_WATCHDOG_EN
    for (int k = 1; k <= 110; k++) begin
      cycle();
      if (k == 1 || k == WDT) begin
        vectors++;
        if (s_active !== 1'b1 || s_fault !== 1'b0) begin
          errors++; $display("FAIL wdt_pre k=%0d active=%b fault=%b want 1/0", k, s_active, s_fault);
        end
      end
      if (k == WDT + 1 || k == 110) begin
        vectors++;
        if (s_active !== 1'b0 || s_fault !== 1'b1 || s_restart !== 1'b0) begin
          errors++; $display("FAIL wdt_trip k=%0d active=%b fault=%b restart=%b want 0/1/0", k, s_active, s_fault, s_restart);
        end
      end
    end
`else
    for (int k = 1; k <= 300; k++) begin
      cycle();
      if (k == 1 || k == 150 || k == 300) begin
        vectors++;
        if (s_active !== 1'b1 || s_fault !== 1'b0) begin
          errors++; $display("FAIL stall k=%0d active=%b fault=%b want 1/0", k, s_active, s_fault);
        end
      end
    end
`endif
    apply_reset();
    #1;
    vectors++;
    if (wdt_fault !== 1'b0 || scan_active !== 1'b0) begin
      errors++; $display("FAIL wdt_reset fault=%b active=%b want 0/0", wdt_fault, scan_active);
    end
  endtask

  initial begin
    ui_val = 8'd0; ui_rand = 1'b1; gap_pct = 0; mode_v = 2'd0;
    test_reset();
    test_header_auto();
    test_halt();
    test_stale_byte();
    test_input_image();
    test_trig();
    test_random();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule
